// File: rtl/fft_peak_pkg.sv
// Shared types and helpers for the FFT peak picker and its magnitude stage.
package fft_peak_pkg;

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, EMIT, FIN, WAIT_LOW} peak_state_t;

  localparam int PIPE_DEPTH   = 2;
  localparam int MAG_W_FACTOR = 2;

  // Octave band of a bin: MSB position relative to the first band's exponent.
  function automatic int band_of(input logic [31:0] bin, input int first_log2);
    int msb;
    msb = 0;
    for (int i = 0; i < 32; i++) if (bin[i]) msb = i;
    return msb - first_log2;
  endfunction

endpackage

// File: rtl/complex_mag_sq.sv
// Registered re^2 + im^2 with valid passthrough; the sum is unsigned and never wraps.
module complex_mag_sq
  import fft_peak_pkg::*;
#(
  parameter int DW = 16,
  localparam int MW = MAG_W_FACTOR * DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  output logic                 mag_valid,
  output logic [MW-1:0]        mag
);

  logic signed [MW-1:0] re_x, im_x, sq_re, sq_im;

  assign re_x  = re;
  assign im_x  = im;
  assign sq_re = re_x * re_x;
  assign sq_im = im_x * im_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_valid <= 1'b0;
      mag       <= '0;
    end else begin
      mag_valid <= valid;
      if (valid) mag <= $unsigned(sq_re) + $unsigned(sq_im);
    end
  end

endmodule

// File: rtl/fft_peak_picker.sv
// Per-octave spectral peak extractor behind the FFT core's DMA port.
// Optional PEAK_THRESHOLD_EN: adds mag_threshold and skips bands whose best mag falls below it.
module fft_peak_picker
  import fft_peak_pkg::*;
#(
  parameter int FFT_LENGTH      = 1024,
  parameter int FFT_DW          = 16,
  parameter int FFT_N           = $clog2(FFT_LENGTH),
  parameter int FIRST_BAND_LOG2 = 3,
  parameter int NUM_BANDS       = 6,
  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1,
  localparam int MAG_W  = MAG_W_FACTOR * FFT_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fft_done,
  input  logic [7:0]               fft_bfpexp,
  output logic                     dmaact,
  output logic [FFT_N-1:0]         dmaa,
  input  logic signed [FFT_DW-1:0] dmadr_real,
  input  logic signed [FFT_DW-1:0] dmadr_imag,
  output logic                     fin,
`ifdef PEAK_THRESHOLD_EN
  input  logic [MAG_W-1:0]         mag_threshold,
`endif
  output logic                     pk_valid,
  input  logic                     pk_ready,
  output logic [BAND_W-1:0]        pk_band,
  output logic [FFT_N-1:0]         pk_bin,
  output logic [MAG_W-1:0]         pk_mag,
  output logic [7:0]               pk_exp,
  output logic                     pk_last
);

  if (FIRST_BAND_LOG2 + NUM_BANDS > FFT_N - 1) begin : g_bad_cfg
    $error("fft_peak_picker: FIRST_BAND_LOG2+NUM_BANDS exceeds FFT_N-1");
  end

  localparam logic [FFT_N-1:0] FIRST_BIN = FFT_N'(1) << FIRST_BAND_LOG2;
  localparam logic [FFT_N-1:0] LAST_BIN  = FFT_N'((1 << (FIRST_BAND_LOG2 + NUM_BANDS)) - 1);

  typedef struct packed {
    logic [FFT_N-1:0] bin;
    logic [MAG_W-1:0] mag;
  } band_rec_t;

  peak_state_t      state, state_nxt;
  band_rec_t        best [NUM_BANDS];
  band_rec_t        best_nxt [NUM_BANDS];
  logic [1:0]       drain_cnt;
  logic             drain_done;
  logic             data_vld, mag_valid;
  logic [FFT_N-1:0] bin_d1, bin_d2;
  logic [MAG_W-1:0] mag;
  logic [BAND_W-1:0] upd_band;
  logic [NUM_BANDS-1:0] qual;
  logic             any_q, first_last, nxt_last, load, load_last;
  logic [BAND_W-1:0] first_idx, nxt_idx, load_idx;
  logic             dmaact_nxt, fin_nxt, pk_valid_nxt;
  logic [FFT_N-1:0] dmaa_nxt;

  // Bin tag travels alongside the data: address cycle -> data cycle -> mag cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_vld <= 1'b0;
      bin_d1   <= '0;
      bin_d2   <= '0;
    end else begin
      data_vld <= dmaact;
      bin_d1   <= dmaa;
      bin_d2   <= bin_d1;
    end
  end

  complex_mag_sq #(.DW(FFT_DW)) u_mag (
    .clk       (clk),
    .rst       (rst),
    .valid     (data_vld && state != IDLE),
    .re        (dmadr_real),
    .im        (dmadr_imag),
    .mag_valid (mag_valid),
    .mag       (mag)
  );

  assign upd_band = BAND_W'(band_of(32'(bin_d2), FIRST_BAND_LOG2));

  // Strictly-greater replace with ascending bins keeps the lowest bin on ties.
  always_comb begin
    best_nxt = best;
    if (state == IDLE) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        best_nxt[k].bin = FIRST_BIN << k;
        best_nxt[k].mag = '0;
      end
    end else if (mag_valid && (state == SCAN || state == DRAIN) &&
                 int'(upd_band) < NUM_BANDS && mag > best[upd_band].mag) begin
      best_nxt[upd_band] = '{bin: bin_d2, mag: mag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int k = 0; k < NUM_BANDS; k++) best[k] <= '0;
    else     best <= best_nxt;
  end

  always_comb begin
    for (int k = 0; k < NUM_BANDS; k++) begin
`ifdef PEAK_THRESHOLD_EN
      qual[k] = best_nxt[k].mag >= mag_threshold;
`else
      qual[k] = 1'b1;
`endif
    end
  end

  // Selection reads best_nxt so the final DRAIN update is visible when loading band 0.
  always_comb begin
    any_q      = |qual;
    first_idx  = '0;
    nxt_idx    = '0;
    first_last = 1'b1;
    nxt_last   = 1'b1;
    for (int k = NUM_BANDS - 1; k >= 0; k--) begin
      if (qual[k]) first_idx = BAND_W'(k);
      if (qual[k] && k > int'(pk_band)) nxt_idx = BAND_W'(k);
    end
    for (int k = 0; k < NUM_BANDS; k++) begin
      if (qual[k] && k > int'(first_idx)) first_last = 1'b0;
      if (qual[k] && k > int'(nxt_idx))   nxt_last   = 1'b0;
    end
  end

  assign drain_done = drain_cnt == 2'(PIPE_DEPTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (fft_done) state_nxt = SCAN;
      SCAN:     if (!fft_done) state_nxt = IDLE;
                else if (dmaa == LAST_BIN) state_nxt = DRAIN;
      DRAIN:    if (!fft_done) state_nxt = IDLE;
                else if (drain_done) state_nxt = any_q ? EMIT : FIN;
      EMIT:     if (!fft_done) state_nxt = IDLE;
                else if (pk_valid && pk_ready && pk_last) state_nxt = FIN;
      FIN:      state_nxt = WAIT_LOW;
      WAIT_LOW: if (!fft_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmaact_nxt   = state_nxt == SCAN;
    dmaa_nxt     = '0;
    if (state_nxt == SCAN) dmaa_nxt = (state == SCAN) ? dmaa + 1'b1 : FIRST_BIN;
    fin_nxt      = state_nxt == FIN;
    pk_valid_nxt = state_nxt == EMIT;
    load         = 1'b0;
    load_idx     = first_idx;
    load_last    = first_last;
    if (state == DRAIN && state_nxt == EMIT) begin
      load = 1'b1;
    end else if (state == EMIT && state_nxt == EMIT && pk_valid && pk_ready) begin
      load      = 1'b1;
      load_idx  = nxt_idx;
      load_last = nxt_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmaact   <= 1'b0;
      dmaa     <= '0;
      fin      <= 1'b0;
      pk_valid <= 1'b0;
      pk_last  <= 1'b0;
      pk_band  <= '0;
      pk_bin   <= '0;
      pk_mag   <= '0;
      pk_exp   <= '0;
    end else begin
      dmaact   <= dmaact_nxt;
      dmaa     <= dmaa_nxt;
      fin      <= fin_nxt;
      pk_valid <= pk_valid_nxt;
      if (state == IDLE && state_nxt == SCAN) pk_exp <= fft_bfpexp;
      if (load) begin
        pk_band <= load_idx;
        pk_bin  <= best_nxt[load_idx].bin;
        pk_mag  <= best_nxt[load_idx].mag;
        pk_last <= load_last;
      end else if (!pk_valid_nxt) begin
        pk_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_picker.sv
// Scoreboard bench for fft_peak_picker: spectrum model, DMA responder, record/fin/scan monitor.
module tb_fft_peak_picker;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fft_done = 1'b0;
  logic [7:0]         fft_bfpexp = 8'h00;
  logic               dmaact;
  logic [9:0]         dmaa;
  logic signed [15:0] dmadr_real, dmadr_imag;
  logic               fin, pk_valid, pk_last;
  logic               pk_ready = 1'b1;
  logic [2:0]         pk_band;
  logic [9:0]         pk_bin;
  logic [31:0]        pk_mag;
  logic [7:0]         pk_exp;
`ifdef PEAK_THRESHOLD_EN
  logic [31:0]        thr = 32'd0;
`endif

  always #5 clk = ~clk;

  fft_peak_picker dut (
    .clk        (clk),
    .rst        (rst),
    .fft_done   (fft_done),
    .fft_bfpexp (fft_bfpexp),
    .dmaact     (dmaact),
    .dmaa       (dmaa),
    .dmadr_real (dmadr_real),
    .dmadr_imag (dmadr_imag),
    .fin        (fin),
`ifdef PEAK_THRESHOLD_EN
    .mag_threshold (thr),
`endif
    .pk_valid   (pk_valid),
    .pk_ready   (pk_ready),
    .pk_band    (pk_band),
    .pk_bin     (pk_bin),
    .pk_mag     (pk_mag),
    .pk_exp     (pk_exp),
    .pk_last    (pk_last)
  );

  typedef struct {
    int         band;
    int         bin;
    longint     mag;
    logic [7:0] exp;
    bit         last;
  } rec_t;

  rec_t               q[$];
  logic signed [15:0] sre [0:1023];
  logic signed [15:0] sim [0:1023];
  int checks = 0, errors = 0, cyc = 0, frame_base = 0;
  int scan_cnt, scan_err, first_dma, fin_cnt, fin_at, vld_cnt, stall_left;
  bit          hold_pend = 1'b0;
  logic [9:0]  h_bin;
  logic [31:0] h_mag;
  logic [2:0]  h_band;
  logic        h_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DMA responder: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (dmaact) begin
      dmadr_real <= sre[dmaa];
      dmadr_imag <= sim[dmaa];
    end else begin
      dmadr_real <= 16'sh5a5a;
      dmadr_imag <= -16'sd1234;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (dmaact) begin
      if (scan_cnt == 0) first_dma = cyc - frame_base;
      if (int'(dmaa) != 8 + scan_cnt) scan_err++;
      scan_cnt++;
    end
    if (fin) begin
      fin_cnt++;
      fin_at = cyc - frame_base;
    end
    if (pk_valid) vld_cnt++;
    if (hold_pend) begin
      chk("hold_vld",  pk_valid, 1'b1);
      chk("hold_band", pk_band, h_band);
      chk("hold_bin",  pk_bin, h_bin);
      chk("hold_mag",  pk_mag, h_mag);
      chk("hold_last", pk_last, h_last);
    end
    hold_pend = pk_valid && !pk_ready;
    h_band = pk_band; h_bin = pk_bin; h_mag = pk_mag; h_last = pk_last;
    if (pk_valid && pk_ready) begin
      chk("rec_expected", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        rec_t e;
        e = q.pop_front();
        chk("rec_band", pk_band, e.band);
        chk("rec_bin",  pk_bin, e.bin);
        chk("rec_mag",  pk_mag, e.mag);
        chk("rec_exp",  pk_exp, e.exp);
        chk("rec_last", pk_last, e.last);
      end
    end
  end

  task automatic clear_spec();
    for (int b = 0; b < 1024; b++) begin
      sre[b] = '0;
      sim[b] = '0;
    end
  endtask

  task automatic mon_clear();
    scan_cnt = 0; scan_err = 0; first_dma = -1;
    fin_cnt = 0; fin_at = -1; vld_cnt = 0;
  endtask

  // Reference: strongest bin per octave band, lowest bin on ties.
  task automatic model(input logic [7:0] e);
    for (int k = 0; k < 6; k++) begin
      rec_t r;
      int lo;
      lo = 1 << (3 + k);
      r.band = k; r.bin = lo; r.mag = 0; r.exp = e; r.last = 1'b0;
      for (int b = lo; b < 2 * lo; b++) begin
        longint re, im, m;
        re = sre[b];
        im = sim[b];
        m  = re * re + im * im;
        if (m > r.mag) begin r.mag = m; r.bin = b; end
      end
`ifdef PEAK_THRESHOLD_EN
      if (r.mag >= longint'(thr)) q.push_back(r);
`else
      q.push_back(r);
`endif
    end
    if (q.size() != 0) q[q.size() - 1].last = 1'b1;
  endtask

  task automatic raise(input logic [7:0] e);
    mon_clear();
    @(posedge clk); #1;
    fft_bfpexp = e;
    fft_done   = 1'b1;
    frame_base = cyc + 1;
  endtask

  task automatic run_frame(input logic [7:0] e, input int fin_exp, input int stall);
    int n;
    model(e);
    stall_left = stall;
    raise(e);
    n = 0;
    while (fin_cnt == 0 && n < 3000) begin
      @(posedge clk); #1;
      pk_ready = 1'b1;
      if (pk_valid && pk_band == 3'd2 && stall_left > 0) begin
        pk_ready = 1'b0;
        stall_left--;
      end
      n++;
    end
    pk_ready = 1'b1;
    chk("fin_seen", fin_cnt > 0, 1'b1);
    fft_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("fin_cnt",    fin_cnt, 1);
    chk("fin_cyc",    fin_at, fin_exp);
    chk("q_empty",    q.size(), 0);
    chk("scan_cnt",   scan_cnt, 504);
    chk("scan_first", first_dma, 1);
    chk("scan_err",   scan_err, 0);
    q.delete();
  endtask

  initial begin
    clear_spec();
    mon_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl",  {dmaact, dmaa, fin, pk_valid, pk_last, pk_band}, 0);
    chk("rst_data", {pk_bin, pk_mag, pk_exp}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single tone, band 3: mag 250000 at bin 100
    sre[100] = 16'sd300; sim[100] = -16'sd400;
    run_frame(8'hfd, 513, 0);

    // Tie inside band 2
    clear_spec();
    sre[40] = 16'sd10; sim[40] = 16'sd10;
    sre[50] = 16'sd10; sim[50] = 16'sd10;
    run_frame(8'h05, 513, 0);

    // Extreme corner: 0x80000000 without wrap
    clear_spec();
    sre[8] = -16'sd32768; sim[8] = -16'sd32768;
    run_frame(8'h80, 513, 0);

    // Backpressure on band 2 for five cycles
    clear_spec();
    sre[9] = 16'sd7; sre[20] = -16'sd5; sim[20] = 16'sd3;
    sre[45] = 16'sd100; sim[33] = -16'sd100;
    sre[90] = 16'sd1; sre[300] = -16'sd2000;
    run_frame(8'h11, 518, 5);

    // Abort at cycle 200, then a clean frame
    clear_spec();
    sre[100] = 16'sd300; sim[100] = -16'sd400;
    raise(8'h22);
    repeat (200) @(posedge clk);
    #1;
    fft_done = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_fin",  fin_cnt, 0);
    chk("abort_vld",  vld_cnt, 0);
    chk("abort_scan", scan_cnt, 200);
    chk("abort_dma",  dmaact, 1'b0);
    run_frame(8'h22, 513, 0);

    // Asynchronous reset mid-scan
    raise(8'h33);
    repeat (100) @(posedge clk);
    #3;
    chk("pre_rst_dma", dmaact, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_dmaact", dmaact, 1'b0);
    chk("rst_dmaa",   dmaa, 0);
    @(posedge clk); #1;
    fft_done = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_frame(8'h33, 513, 0);

    // Random sparse spectrum
    clear_spec();
    repeat (40) begin
      int b;
      b = $urandom_range(511, 8);
      sre[b] = 16'($urandom);
      sim[b] = 16'($urandom);
    end
    run_frame(8'h7f, 513, 0);

`ifdef PEAK_THRESHOLD_EN
    // Only band 4 clears the threshold
    clear_spec();
    sre[10] = 16'sd5; sim[10] = 16'sd5;
    sre[70] = 16'sd20;
    sre[200] = 16'sd100;
    thr = 32'd1000;
    run_frame(8'h44, 508, 0);
    thr = 32'd0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_peak_picker.md
# fft_peak_picker

Frame-level spectral peak extractor that sits directly downstream of the radix-2 FFT core. Once the core reports `done`, the block reads the positive-frequency bins over the core's DMA bus and computes |X|² for each. It finds the strongest bin in each octave band, emits one peak record per band on a valid/ready stream, and then pulses `fin` to release the core for the next frame. The peak records feed the fingerprint hasher.

## Interface
- `FFT_LENGTH`, 1024, FFT frame length, a power of 2.
- `FFT_DW`, 16, signed real/imag width.
- `FFT_N`, $clog2(FFT_LENGTH), derived; never overridden.
- `FIRST_BAND_LOG2`, 3, band 0 starts at bin 2^FIRST_BAND_LOG2.
- `NUM_BANDS`, 6, octave band count. Elaboration error unless FIRST_BAND_LOG2+NUM_BANDS ≤ FFT_N−1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `fft_done`  in  1  FFT core frame-complete level.
- `fft_bfpexp`  in  8  signed block-floating-point exponent of the current frame.
- `dmaact`  out  1  DMA read strobe to the core.
- `dmaa`  out  FFT_N  DMA bin address.
- `dmadr_real`, `dmadr_imag`  in  FFT_DW each  DMA read data, valid the cycle after `dmaact`.
- `fin`  out  1  one-cycle release pulse to the core.
- `pk_valid`  out  1  peak record valid.
- `pk_ready`  in  1  consumer accept.
- `pk_band`  out  $clog2(NUM_BANDS)  band index.
- `pk_bin`  out  FFT_N  peak bin index.
- `pk_mag`  out  2*FFT_DW  unsigned re²+im².
- `pk_exp`  out  8  frame exponent, latched at scan start.
- `pk_last`  out  1  high on the final record of the frame.

## Operation
- States: IDLE, SCAN, DRAIN, EMIT, FIN, WAIT_LOW.
- IDLE:
  - `fft_done`=1 moves to SCAN.
  - Latches `fft_bfpexp`.
  - Clears all band results to {bin = band start, mag = 0}.
- SCAN:
  - Issues `dmaact`=1 every cycle, with `dmaa` stepping from 2^FIRST_BAND_LOG2 to 2^(FIRST_BAND_LOG2+NUM_BANDS)−1.
  - After the last address, moves to DRAIN.
- Band membership: band k = [2^(FIRST_BAND_LOG2+k), 2^(FIRST_BAND_LOG2+k+1)). Band index = position of the bin MSB − FIRST_BAND_LOG2.
- Magnitude arithmetic:
  - re² and im² are signed products; their sum is unsigned 2*FFT_DW bits.
  - The largest value, 2·2^(2FFT_DW−2), fits without overflow.
  - No saturation and no rounding.
- Compare: replace a band's best only if mag is strictly greater. On ties the lower bin wins.
- DRAIN: 2 cycles to flush the pipeline, then EMIT.
- EMIT:
  - Presents band 0..NUM_BANDS−1 in order, with `pk_last` on band NUM_BANDS−1.
  - `pk_valid` and all fields stay stable until `pk_ready`.
  - A record transfers on a cycle with `pk_valid`&`pk_ready`. The next record is presented the following cycle; there are no bubbles if `pk_ready` stays high.
- FIN: `fin`=1 for exactly one cycle after the last transfer, then WAIT_LOW.
- WAIT_LOW: returns to IDLE when `fft_done`=0. This prevents rescanning the same frame.
- Abort: `fft_done` falling in SCAN, DRAIN or EMIT returns to IDLE next cycle. `pk_valid` drops, no `fin` is issued, and results are discarded.

## Timing
- Reset values: `dmaact`=0, `dmaa`=0, `fin`=0, `pk_valid`=0, `pk_last`=0. `pk_band`, `pk_bin`, `pk_mag` and `pk_exp` are all 0.
- All outputs are registered.
- Pipeline: address issued in cycle c, data arrives in c+1, mag register in c+2, band best updated at the end of c+2.
- Default parameters, with `fft_done` first seen in IDLE at cycle 0:
  - SCAN occupies cycles 1–504 (bins 8–511).
  - DRAIN occupies 505–506.
  - First `pk_valid` at cycle 507.
  - With `pk_ready` tied high, `fin` is at cycle 513.
- `rst` mid-operation: outputs clear immediately (asynchronously) and state returns to IDLE.

## Configuration
- `PEAK_THRESHOLD_EN` defined:
  - Adds input port `mag_threshold` (2*FFT_DW).
  - Bands whose best mag < `mag_threshold` are skipped in EMIT and take no cycles.
  - `pk_last` marks the last emitted record.
  - If no band qualifies, FIN follows DRAIN directly.
- `PEAK_THRESHOLD_EN` undefined: no port; every band is emitted.

## Structure
- Package `fft_peak_pkg` holds:
  - the state enum `peak_state_t`;
  - a band-index function of (bin, FIRST_BAND_LOG2);
  - localparams for pipeline depth (2) and magnitude width.
- Sub-module `complex_mag_sq`: a registered re²+im² stage with a valid passthrough. It is reused by the hasher.
- Band results are kept in a NUM_BANDS-entry register array of {bin, mag}.

## Test plan
- Single tone: all bins 0 except bin 100 = (300, −400). Band 3 reports bin 100, mag 250000. Other bands report their start bin with mag 0. `fin` is one cycle at 513.
- Tie: bins 40 and 50 both (10, 10). Band 2 reports bin 40, mag 200.
- Extreme value: bin 8 = (−32768, −32768). Band 0 reports mag 0x80000000 with no wrap.
- Backpressure: `pk_ready` low for 5 cycles on band 2. Fields stay stable, no record is lost, and `pk_last` appears only on band 5.
- Abort and reset:
  - `fft_done` dropped at cycle 200: no `fin` and no `pk_valid`; a new frame then scans cleanly.
  - `rst` pulsed mid-SCAN: `dmaact` goes to 0 immediately.
- `PEAK_THRESHOLD_EN` with threshold 1000 and only band 4 above it: exactly one record, band 4, with `pk_last`=1.
